// File: rtl/stage_frame_fifo_pkg.sv
// Shared types and defaults for the stage frame FIFO.
//   float_24_8           : packed word carried by the FIFO (24-bit mantissa, 8-bit exponent)
//   STAGE_FRAME_LEN_DEF  : default words per frame
//   STAGE_FIFO_DEPTH_DEF : default FIFO depth
//   STAGE_AF_LEVEL_DEF   : default almost-full threshold
//   cnt_w()              : width needed to hold the values 0..n
package stage_frame_fifo_pkg;

  typedef struct packed {
    logic [23:0] mant;
    logic [7:0]  expo;
  } float_24_8;

  localparam int STAGE_FRAME_LEN_DEF  = 12;
  localparam int STAGE_FIFO_DEPTH_DEF = 16;
  localparam int STAGE_AF_LEVEL_DEF   = 12;

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/stage_frame_fifo_ram.sv
// Storage array for the stage frame FIFO.
//   clk     : write clock
//   wr_en   : write strobe
//   wr_addr : write index
//   wr_data : word written, {fst, data}
//   rd_addr : read index
//   rd_data : word at rd_addr, combinational (lets the head fall through)
// The array carries no reset; the controller masks the read data while empty.
module stage_frame_fifo_ram #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stage_frame_fifo.sv
// Framed stream FIFO between a network stage controller and its consumer.
// First-word fall-through, registered in_rdy/level/almost_full, an input
// frame checker with a sticky error flag, and a completed-frame counter.
//   clk, reset            : clock, async active-low reset
//   flush                 : sync clear of contents, checker state and error
//   in_data/in_fst/in_vld : write side, in_rdy = FIFO can accept
//   out_data/out_fst/out_vld : head word, out_rdy = consumer accepts
//   almost_full           : level >= AF_LEVEL
//   level                 : stored word count
//   frame_err             : sticky framing violation
//   frames_done           : completed frames popped (wraps, survives flush)
module stage_frame_fifo
  import stage_frame_fifo_pkg::*;
#(
  parameter int WIDTH     = $bits(float_24_8),
  parameter int DEPTH     = STAGE_FIFO_DEPTH_DEF,
  parameter int FRAME_LEN = STAGE_FRAME_LEN_DEF,
  parameter int AF_LEVEL  = STAGE_AF_LEVEL_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_fst,
  input  logic                     in_vld,
  output logic                     in_rdy,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_fst,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     frame_err,
  output logic [15:0]              frames_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = cnt_w(FRAME_LEN);

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_LEVEL);
  localparam logic [CW-1:0] FLEN    = CW'(FRAME_LEN);
  localparam logic [CW-1:0] FLAST   = CW'(FRAME_LEN - 1);
  // a lone fst word already completes a frame when FRAME_LEN is 1
  localparam logic [CW-1:0] IRESYNC = (FRAME_LEN == 1) ? '0 : CW'(1);

  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [LW-1:0]  level_nxt;
  logic [WIDTH:0] rd_word;
  logic           push, pop;

  logic [CW-1:0]  icnt, icnt_nxt;
  logic [CW-1:0]  ocnt, ocnt_inc;
  logic           err_set, frame_pop;

  // flush wins over both handshakes so nothing moves on a flush edge
  assign push = in_vld & in_rdy & ~flush;
  assign pop  = out_vld & out_rdy & ~flush;

  stage_frame_fifo_ram #(
    .WIDTH (WIDTH + 1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data ({in_fst, in_data}),
    .rd_addr (rd_ptr),
    .rd_data (rd_word)
  );

  // head is driven to zero while empty, since the array has no reset
  assign out_data = out_vld ? rd_word[WIDTH-1:0] : '0;
  assign out_fst  = out_vld & rd_word[WIDTH];

  always_comb begin
    level_nxt = level;
    if (flush)             level_nxt = '0;
    else if (push && !pop) level_nxt = level + LW'(1);
    else if (!push && pop) level_nxt = level - LW'(1);
  end

  // handshake flags are registered from the next level, so in_rdy never
  // depends combinationally on out_rdy and a full FIFO refuses a push even
  // when the head is popped in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      in_rdy      <= 1'b0;
      out_vld     <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      level       <= level_nxt;
      in_rdy      <= (level_nxt != DEPTH_L);
      out_vld     <= (level_nxt != '0);
      almost_full <= (level_nxt >= AF_L);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // input frame checker: fst must land exactly on word 0 of each frame;
  // any fst resyncs the position so one bad frame does not poison the rest
  always_comb begin
    icnt_nxt = icnt;
    err_set  = 1'b0;
    if (push) begin
      if (in_fst) begin
        err_set  = (icnt != '0);
        icnt_nxt = IRESYNC;
      end else begin
        err_set  = (icnt == '0);
        icnt_nxt = (icnt == FLAST) ? '0 : icnt + CW'(1);
      end
    end
  end

  // output side: count popped words, fst restarts the count
  assign ocnt_inc  = out_fst ? CW'(1) : ocnt + CW'(1);
  assign frame_pop = pop & (ocnt_inc == FLEN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      icnt        <= '0;
      ocnt        <= '0;
      frame_err   <= 1'b0;
      frames_done <= '0;
    end else if (flush) begin
      icnt      <= '0;
      ocnt      <= '0;
      frame_err <= 1'b0;
    end else begin
      icnt <= icnt_nxt;
      if (err_set) frame_err <= 1'b1;
      if (pop)     ocnt <= frame_pop ? '0 : ocnt_inc;
      if (frame_pop) frames_done <= frames_done + 16'd1;
    end
  end

endmodule
